// File: rtl/pulse_gen.sv
// pulse_gen: delayed pulse generator fed by the lut output.
// Each accepted input edge is queued with a due timestamp D = max(DELAY,3)
// ticks in the future. When the queue head falls due it is popped and either
// starts a WIDTH-tick pulse (WIDTH>0, rising edges only) or replays the
// recorded input level (WIDTH=0, delay-line mode).
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   enable_i                1 = accept edges, 0 = flush and idle
//   inp_i                   input bit
//   DELAY / DELAY_WSTB      delay in ticks and its write strobe
//   WIDTH / WIDTH_WSTB      pulse width (0 = delay line) and its write strobe
//   out_o                   delayed pulse / delayed waveform
//   perr_o                  one-tick strobe for a dropped edge
//   missed_cnt_o            saturating count of dropped edges
//   queued_o                queue occupancy after this tick's push/pop
module pulse_gen #(
    parameter int unsigned QUEUE_DEPTH = 16,
    parameter int unsigned TS_W        = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic                           inp_i,
    input  logic [31:0]                    DELAY,
    input  logic                           DELAY_WSTB,
    input  logic [31:0]                    WIDTH,
    input  logic                           WIDTH_WSTB,
    output logic                           out_o,
    output logic                           perr_o,
    output logic [31:0]                    missed_cnt_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queued_o
);

    localparam int unsigned AW    = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CMP_W = ((TS_W > 32) ? TS_W : 32) + 1;

    // Edge queue storage
    logic [TS_W-1:0] r_due_mem [QUEUE_DEPTH];
    logic            r_lvl_mem [QUEUE_DEPTH];

    logic [TS_W-1:0] r_ts;
    logic            r_prev;
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            r_out;
    logic [31:0]     r_cnt;
    logic            r_perr;
    logic [31:0]     r_missed;
    logic [TS_W-1:0] r_last_ts;
    logic            r_have_last;

    logic            w_flush;
    logic            w_edge;
    logic            w_rise;
    logic            w_wmode0;
    logic [31:0]     w_d_eff;
    logic [TS_W-1:0] w_due;
    logic            w_pop;
    logic            w_cand;
    logic            w_overlap;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [CMP_W-1:0] w_age;
    logic [CMP_W-1:0] w_lim;

    // Edge classification, overlap/full checks and push/pop decisions
    always_comb begin
        w_flush   = DELAY_WSTB | WIDTH_WSTB | ~enable_i;
        w_edge    = inp_i ^ r_prev;
        w_rise    = inp_i & ~r_prev;
        w_wmode0  = (WIDTH == 32'd0);
        w_d_eff   = (DELAY < 32'd3) ? 32'd3 : DELAY;
        w_due     = r_ts + TS_W'(w_d_eff);
        w_age     = CMP_W'(r_ts - r_last_ts);
        w_lim     = CMP_W'(WIDTH) + CMP_W'(1);
        w_pop     = ~w_flush && (r_count != CW'(0)) && (r_due_mem[r_rd] == r_ts);
        w_cand    = ~w_flush && (w_wmode0 ? w_edge : w_rise);
        w_overlap = ~w_wmode0 && r_have_last && (w_age < w_lim);
        // A pop in the same tick frees the slot before the push lands
        w_full    = (r_count == CW'(QUEUE_DEPTH)) && ~w_pop;
        w_push    = w_cand && ~w_overlap && ~w_full;
        w_drop    = w_cand && (w_overlap || w_full);
    end

    // Queue payload writes (no reset needed; validity tracked by r_count)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_due_mem[r_wr] <= w_due;
            r_lvl_mem[r_wr] <= inp_i;
        end
    end

    // Control state, pointers and output shaping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ts        <= '0;
            r_prev      <= 1'b0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_out       <= 1'b0;
            r_cnt       <= '0;
            r_perr      <= 1'b0;
            r_missed    <= '0;
            r_last_ts   <= '0;
            r_have_last <= 1'b0;
        end else begin
            r_ts   <= r_ts + TS_W'(1);
            r_prev <= inp_i;
            r_perr <= w_drop;
            if (w_drop && (r_missed != 32'hFFFF_FFFF)) begin
                r_missed <= r_missed + 32'd1;
            end
            if (w_flush) begin
                r_wr        <= '0;
                r_rd        <= '0;
                r_count     <= '0;
                r_out       <= 1'b0;
                r_cnt       <= '0;
                r_have_last <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + AW'(1);
                    if (~w_wmode0) begin
                        r_last_ts   <= r_ts;
                        r_have_last <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_pop) begin
                    if (w_wmode0) begin
                        r_out <= r_lvl_mem[r_rd];
                    end else begin
                        r_out <= 1'b1;
                        r_cnt <= WIDTH - 32'd1;
                    end
                end else if (~w_wmode0) begin
                    // Hold for WIDTH ticks total including the pop tick
                    if (r_cnt != 32'd0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else begin
                        r_out <= 1'b0;
                    end
                end
            end
        end
    end

    assign out_o        = r_out;
    assign perr_o       = r_perr;
    assign missed_cnt_o = r_missed;
    assign queued_o     = r_count;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: tick-by-tick expected waveforms per scenario.
module tb_pulse_gen;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        inp_i;
    logic [31:0] DELAY;
    logic        DELAY_WSTB;
    logic [31:0] WIDTH;
    logic        WIDTH_WSTB;
    logic        out_o;
    logic        perr_o;
    logic [31:0] missed_cnt_o;
    logic [4:0]  queued_o;

    int checks   = 0;
    int failures = 0;

    pulse_gen #(.QUEUE_DEPTH(16), .TS_W(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .inp_i       (inp_i),
        .DELAY       (DELAY),
        .DELAY_WSTB  (DELAY_WSTB),
        .WIDTH       (WIDTH),
        .WIDTH_WSTB  (WIDTH_WSTB),
        .out_o       (out_o),
        .perr_o      (perr_o),
        .missed_cnt_o(missed_cnt_o),
        .queued_o    (queued_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one tick; outputs are then stable, inputs for next tick may be set
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load DELAY/WIDTH with strobes, then settle two idle ticks
    task automatic cfg(input logic [31:0] d, input logic [31:0] w);
        DELAY      = d;
        WIDTH      = w;
        DELAY_WSTB = 1'b1;
        WIDTH_WSTB = 1'b1;
        enable_i   = 1'b1;
        inp_i      = 1'b0;
        step();
        DELAY_WSTB = 1'b0;
        WIDTH_WSTB = 1'b0;
        step();
        step();
        chk("cfg_queued", 32'(queued_o), 32'd0);
        chk("cfg_out", 32'(out_o), 32'd0);
    endtask

    initial begin
        logic exp_out;
        logic exp_perr;
        int   peak;
        int   rises;
        logic prev_out;

        reset_i    = 1'b1;
        enable_i   = 1'b0;
        inp_i      = 1'b0;
        DELAY      = 32'd0;
        WIDTH      = 32'd0;
        DELAY_WSTB = 1'b0;
        WIDTH_WSTB = 1'b0;
        step();
        step();
        step();
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_perr", 32'(perr_o), 32'd0);
        chk("rst_missed", missed_cnt_o, 32'd0);
        chk("rst_queued", 32'(queued_o), 32'd0);
        reset_i = 1'b0;
        step();

        // 1: single rising edge, DELAY=10 WIDTH=5
        cfg(32'd10, 32'd5);
        for (int t = 0; t < 20; t++) begin
            inp_i = (t < 3);
            step();
            exp_out = (t >= 10 && t <= 14);
            chk($sformatf("t1_out@%0d", t), 32'(out_o), 32'(exp_out));
            chk($sformatf("t1_perr@%0d", t), 32'(perr_o), 32'd0);
        end

        // 2: three queued edges, DELAY=20 WIDTH=3
        cfg(32'd20, 32'd3);
        peak = 0;
        for (int t = 0; t < 36; t++) begin
            inp_i = (t <= 11) && ((t % 5) < 2);
            step();
            if (int'(queued_o) > peak) peak = int'(queued_o);
            exp_out = (t >= 20 && t <= 22) || (t >= 25 && t <= 27) || (t >= 30 && t <= 32);
            chk($sformatf("t2_out@%0d", t), 32'(out_o), 32'(exp_out));
        end
        chk("t2_peak", 32'(peak), 32'd3);

        // 3: delay-line mode, DELAY=1 clamps to 3
        cfg(32'd1, 32'd0);
        for (int t = 0; t < 14; t++) begin
            inp_i = (t <= 6);
            step();
            exp_out = (t >= 3 && t <= 9);
            chk($sformatf("t3_out@%0d", t), 32'(out_o), 32'(exp_out));
        end

        // 4: 17 edges into a 16-deep queue, DELAY=100 WIDTH=2
        cfg(32'd100, 32'd2);
        rises    = 0;
        prev_out = 1'b0;
        for (int t = 0; t < 170; t++) begin
            inp_i = (t <= 64) && ((t % 4) == 0);
            step();
            if (t == 63) chk("t4_full", 32'(queued_o), 32'd16);
            exp_perr = (t == 64);
            exp_out  = (t >= 100 && t <= 161) && (((t - 100) % 4) < 2);
            chk($sformatf("t4_perr@%0d", t), 32'(perr_o), 32'(exp_perr));
            chk($sformatf("t4_out@%0d", t), 32'(out_o), 32'(exp_out));
            if (out_o && !prev_out) rises++;
            prev_out = out_o;
        end
        chk("t4_pulses", 32'(rises), 32'd16);
        chk("t4_missed", missed_cnt_o, 32'd1);

        // Reset clears the missed counter before the overlap scenario
        DELAY      = 32'd20;
        WIDTH      = 32'd10;
        reset_i    = 1'b1;
        step();
        reset_i    = 1'b0;
        chk("rst2_missed", missed_cnt_o, 32'd0);
        chk("rst2_queued", 32'(queued_o), 32'd0);
        chk("rst2_out", 32'(out_o), 32'd0);
        step();

        // 5: second edge inside WIDTH+1 window is dropped
        for (int t = 0; t < 35; t++) begin
            inp_i = (t <= 1) || (t == 5) || (t == 6);
            step();
            exp_perr = (t == 5);
            exp_out  = (t >= 20 && t <= 29);
            chk($sformatf("t5_perr@%0d", t), 32'(perr_o), 32'(exp_perr));
            chk($sformatf("t5_out@%0d", t), 32'(out_o), 32'(exp_out));
        end
        chk("t5_missed", missed_cnt_o, 32'd1);

        // 6: flush by DELAY_WSTB, then abort a pulse with enable_i=0
        cfg(32'd50, 32'd8);
        for (int t = 0; t < 92; t++) begin
            inp_i      = ((t % 10) < 2) && (t <= 31);
            DELAY_WSTB = (t == 25);
            enable_i   = (t < 83);
            step();
            if (t == 20) chk("t6_q3", 32'(queued_o), 32'd3);
            if (t == 25) chk("t6_flush_q", 32'(queued_o), 32'd0);
            exp_out = (t >= 80 && t <= 82);
            chk($sformatf("t6_out@%0d", t), 32'(out_o), 32'(exp_out));
            chk($sformatf("t6_perr@%0d", t), 32'(perr_o), 32'd0);
        end
        DELAY_WSTB = 1'b0;
        chk("t6_missed_kept", missed_cnt_o, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
